// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write-back path.
// RF_WB_RR_EN (optional define) selects round-robin arbitration in rf_wb_prio.
package rf_pkg;

   localparam int XLEN     = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;

   // Bit positions inside the one-hot grant vector
   localparam int GNT_ALU = 0;
   localparam int GNT_MEM = 1;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } rf_state_e;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_req_t;

endpackage

// File: rtl/rf_wb_prio.sv
// Grant logic for the ALU/load write-back requesters, with its arbitration state.
// Default: fixed mem priority with starvation override; RF_WB_RR_EN: 1-bit round robin.
module rf_wb_prio
   import rf_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       alu_valid,
   input  logic       mem_valid,
   output logic [1:0] grant
);

   logic conflict;
   assign conflict = en && alu_valid && mem_valid;

`ifdef RF_WB_RR_EN

   // Set when the ALU took the last conflicting grant; reset value favours mem.
   logic alu_last_reg;

   always_comb begin
      grant = '0;
      if (conflict) begin
         if (alu_last_reg) grant[GNT_MEM] = 1'b1;
         else              grant[GNT_ALU] = 1'b1;
      end else if (en && alu_valid) begin
         grant[GNT_ALU] = 1'b1;
      end else if (en && mem_valid) begin
         grant[GNT_MEM] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_last_reg <= 1'b1;
      end else if (conflict) begin
         alu_last_reg <= grant[GNT_ALU];
      end
   end

`else

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_reg;
   logic [CNT_W-1:0] starve_next;

   always_comb begin
      grant = '0;
      if (conflict) begin
         if (starve_reg >= LIMIT) grant[GNT_ALU] = 1'b1;
         else                     grant[GNT_MEM] = 1'b1;
      end else if (en && alu_valid) begin
         grant[GNT_ALU] = 1'b1;
      end else if (en && mem_valid) begin
         grant[GNT_MEM] = 1'b1;
      end
   end

   // Counts consecutive denied ALU cycles; saturates at the limit.
   always_comb begin
      starve_next = starve_reg;
      if (!en || !alu_valid || grant[GNT_ALU]) begin
         starve_next = '0;
      end else if (starve_reg < LIMIT) begin
         starve_next = starve_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) starve_reg <= '0;
      else       starve_reg <= starve_next;
   end

`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back controller for the register file write port: post-reset clear of all
// registers, then ALU/load arbitration. RF_WB_RR_EN selects round-robin arbitration.
module rf_wb_arbiter
   import rf_pkg::*;
#(
   parameter int XLEN         = rf_pkg::XLEN,
   parameter int ADDR_W       = rf_pkg::ADDR_W,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_rd,
   input  logic [XLEN-1:0]   alu_data,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [ADDR_W-1:0] mem_rd,
   input  logic [XLEN-1:0]   mem_data,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [XLEN-1:0]   rf_wdata,
   output logic              init_done
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   rf_state_e         state_reg;
   logic [ADDR_W-1:0] clr_idx_reg;
   logic              run_active;
   logic [1:0]        grant;
   wb_req_t           alu_req;
   wb_req_t           mem_req;
   wb_req_t           win;

   // Grants open only once init_done is up, so the last clear write is never overlapped.
   assign run_active = (state_reg == RUN) && init_done;

   rf_wb_prio #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_prio (
      .clk       (clk),
      .reset     (reset),
      .en        (run_active),
      .alu_valid (alu_valid),
      .mem_valid (mem_valid),
      .grant     (grant)
   );

   assign alu_ready = grant[GNT_ALU];
   assign mem_ready = grant[GNT_MEM];

   always_comb begin
      alu_req = '{valid: alu_valid, rd: alu_rd, data: alu_data};
      mem_req = '{valid: mem_valid, rd: mem_rd, data: mem_data};
      win     = grant[GNT_MEM] ? mem_req : alu_req;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= CLEAR;
         clr_idx_reg <= '0;
         rf_we       <= 1'b0;
         rf_waddr    <= '0;
         rf_wdata    <= '0;
         init_done   <= 1'b0;
      end else begin
         case (state_reg)
            CLEAR: begin
               rf_we    <= 1'b1;
               rf_waddr <= clr_idx_reg;
               rf_wdata <= '0;
               if (clr_idx_reg == LAST_IDX) state_reg <= RUN;
               else                         clr_idx_reg <= clr_idx_reg + 1'b1;
            end
            RUN: begin
               init_done <= 1'b1;
               // x0 grants are consumed but leave the port idle and address/data held
               if (win.valid && (|grant) && (win.rd != '0)) begin
                  rf_we    <= 1'b1;
                  rf_waddr <= win.rd;
                  rf_wdata <= win.data;
               end else begin
                  rf_we    <= 1'b0;
               end
            end
            default: state_reg <= CLEAR;
         endcase
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: clear sequence, single request, arbitration,
// x0/same-rd handling and reset mid-run.
module tb_rf_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_valid, mem_valid;
   logic        alu_ready, mem_ready;
   logic [4:0]  alu_rd, mem_rd;
   logic [31:0] alu_data, mem_data;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        init_done;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   rf_wb_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_rd    (mem_rd),
      .mem_data  (mem_data),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .init_done (init_done)
   );

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      alu_valid = 1'b0; mem_valid = 1'b0;
      alu_rd = '0; mem_rd = '0; alu_data = '0; mem_data = '0;
      #1;
      vecs++;
      if ({rf_we, rf_waddr, rf_wdata, init_done, alu_ready, mem_ready} !== '0) begin
         errs++;
         $display("FAIL reset_outputs: we=%b addr=%0d data=%h init=%b ar=%b mr=%b, need all 0",
                  rf_we, rf_waddr, rf_wdata, init_done, alu_ready, mem_ready);
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      $display("reset: released after 3 cycles");
   endtask

   // Both valids held high during the clear so ready suppression is exercised.
   task automatic test_clear();
      alu_valid = 1'b1; mem_valid = 1'b1;
      alu_rd = 5'd1; mem_rd = 5'd2; alu_data = 32'h11; mem_data = 32'h22;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         vecs++;
         if (rf_we !== 1'b1 || rf_waddr !== i[4:0] || rf_wdata !== 32'h0 ||
             init_done !== 1'b0 || alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
            errs++;
            $display("FAIL clear_%0d: we=%b addr=%0d data=%h init=%b ar=%b mr=%b, need we=1 addr=%0d data=0 init=0 ready=0",
                     i, rf_we, rf_waddr, rf_wdata, init_done, alu_ready, mem_ready, i);
         end
      end
      @(negedge clk);
      vecs++;
      if (init_done !== 1'b1 || rf_we !== 1'b0) begin
         errs++;
         $display("FAIL clear_done: init=%b we=%b, need init=1 we=0", init_done, rf_we);
      end
      alu_valid = 1'b0; mem_valid = 1'b0;
      $display("clear: 32 writes checked, init_done=%b", init_done);
   endtask

   task automatic test_single();
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
      #1;
      vecs++;
      if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
         errs++;
         $display("FAIL single_ready: ar=%b mr=%b, need ar=1 mr=0", alu_ready, mem_ready);
      end
      @(negedge clk);
      alu_valid = 1'b0;
      vecs++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin
         errs++;
         $display("FAIL single_write: we=%b addr=%0d data=%h, need 1 5 00001234", rf_we, rf_waddr, rf_wdata);
      end
      @(negedge clk);
      vecs++;
      if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin
         errs++;
         $display("FAIL single_idle: we=%b addr=%0d data=%h, need 0 5 00001234 (held)", rf_we, rf_waddr, rf_wdata);
      end
      $display("single: alu rd=5 data=1234 -> we=%b addr=%0d data=%h", rf_we, rf_waddr, rf_wdata);
   endtask

   // Both requesters held valid; exp_mem[k]=1 means mem must win cycle k.
   task automatic run_conflict(input string name, input int n, input logic [7:0] exp_mem);
      logic prev_mem;
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA3;
      mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h44;
      for (int k = 0; k < n; k++) begin
         #1;
         vecs++;
         if (mem_ready !== exp_mem[k] || alu_ready !== ~exp_mem[k]) begin
            errs++;
            $display("FAIL %s_grant_%0d: mr=%b ar=%b, need mr=%b ar=%b",
                     name, k, mem_ready, alu_ready, exp_mem[k], ~exp_mem[k]);
         end
         prev_mem = exp_mem[k];
         @(negedge clk);
         vecs++;
         if (rf_we !== 1'b1 || rf_waddr !== (prev_mem ? 5'd4 : 5'd3) ||
             rf_wdata !== (prev_mem ? 32'h44 : 32'hA3)) begin
            errs++;
            $display("FAIL %s_write_%0d: we=%b addr=%0d data=%h, need mem_won=%b",
                     name, k, rf_we, rf_waddr, rf_wdata, prev_mem);
         end
         $display("%s: cycle %0d expected %s, wrote addr=%0d", name, k, prev_mem ? "mem" : "alu", rf_waddr);
      end
      alu_valid = 1'b0; mem_valid = 1'b0;
      @(negedge clk);
   endtask

`ifdef RF_WB_RR_EN
   task automatic test_round_robin();
      run_conflict("rr", 4, 8'b0000_0101);
   endtask
`else
   task automatic test_starvation();
      run_conflict("starve", 6, 8'b0010_1111);
   endtask
`endif

   task automatic test_x0_same_rd();
      mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hFF;
      #1;
      vecs++;
      if (mem_ready !== 1'b1) begin
         errs++;
         $display("FAIL x0_ready: mr=%b, need 1", mem_ready);
      end
      @(negedge clk);
      mem_valid = 1'b0;
      vecs++;
      if (rf_we !== 1'b0) begin
         errs++;
         $display("FAIL x0_no_write: we=%b addr=%0d, need we=0", rf_we, rf_waddr);
      end
      $display("x0: mem rd=0 accepted, we=%b", rf_we);

      mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'hA;
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hB;
      #1;
      vecs++;
      if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
         errs++;
         $display("FAIL samerd_first: mr=%b ar=%b, need mr=1 ar=0", mem_ready, alu_ready);
      end
      @(negedge clk);
      mem_valid = 1'b0;
      vecs++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hA) begin
         errs++;
         $display("FAIL samerd_mem_write: we=%b addr=%0d data=%h, need 1 7 0000000a", rf_we, rf_waddr, rf_wdata);
      end
      #1;
      vecs++;
      if (alu_ready !== 1'b1) begin
         errs++;
         $display("FAIL samerd_second: ar=%b, need 1", alu_ready);
      end
      @(negedge clk);
      alu_valid = 1'b0;
      vecs++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hB) begin
         errs++;
         $display("FAIL samerd_alu_write: we=%b addr=%0d data=%h, need 1 7 0000000b", rf_we, rf_waddr, rf_wdata);
      end
      $display("same_rd: final x7 write data=%h", rf_wdata);
      @(negedge clk);
   endtask

   task automatic test_reset_mid_run();
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
      @(negedge clk);
      alu_valid = 1'b0;
      vecs++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd9) begin
         errs++;
         $display("FAIL midrun_prewrite: we=%b addr=%0d, need 1 9", rf_we, rf_waddr);
      end
      reset = 1'b1;
      #1;
      vecs++;
      if ({rf_we, rf_waddr, rf_wdata, init_done} !== '0) begin
         errs++;
         $display("FAIL midrun_async_reset: we=%b addr=%0d data=%h init=%b, need all 0",
                  rf_we, rf_waddr, rf_wdata, init_done);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      $display("reset_mid_run: outputs cleared, restarting clear");
      test_clear();
   endtask

   initial begin
      reset = 1'b1;
      alu_valid = 1'b0; mem_valid = 1'b0;
      alu_rd = '0; mem_rd = '0; alu_data = '0; mem_data = '0;
      test_reset();
      test_clear();
      test_single();
`ifdef RF_WB_RR_EN
      test_round_robin();
`else
      test_starvation();
`endif
      test_reset_mid_run();
      test_x0_same_rd();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back controller for the 32×32 register file's single write port. Sequences a post-reset clear of all registers through the write port, then arbitrates between two writeback requesters (ALU and load/memory unit) with valid/ready handshakes. Sits between the execute/memory stages and the register file's `RegWrite`/`Rd`/`Write_data` inputs.

## Interface
Parameters:
- `XLEN`, 32, data width.
- `ADDR_W`, 5, register address width (32 registers).
- `STARVE_LIMIT`, 4, consecutive lost arbitrations after which the ALU wins (fixed-priority mode only).

Ports:
- `clk` input 1: clock.
- `reset` input 1: reset, asynchronous, active-high.
- `alu_valid` input 1: ALU writeback request.
- `alu_ready` output 1: ALU request accepted this cycle.
- `alu_rd` input `ADDR_W`: ALU destination register.
- `alu_data` input `XLEN`: ALU result.
- `mem_valid` input 1: load writeback request.
- `mem_ready` output 1: load request accepted this cycle.
- `mem_rd` input `ADDR_W`: load destination register.
- `mem_data` input `XLEN`: load data.
- `rf_we` output 1: register file write enable.
- `rf_waddr` output `ADDR_W`: register file write address.
- `rf_wdata` output `XLEN`: register file write data.
- `init_done` output 1: clear sequence finished; arbitration active.

## Operation
- FSM states: CLEAR and RUN.
- On reset, the FSM enters CLEAR with the clear index at 0.
- CLEAR:
  - Each cycle the block drives `rf_we=1`, `rf_waddr=index`, `rf_wdata=0`, then increments the index.
  - After index 31 is issued, the FSM moves to RUN. The index does not wrap.
  - `alu_ready=mem_ready=0` throughout CLEAR.
- RUN:
  - A transfer occurs when valid and ready are both high.
  - At most one grant per cycle.
  - `*_ready` is combinational from the FSM state, both valids and the arbitration state.
  - Fixed priority (default): mem wins conflicts. The starve counter increments each cycle the ALU is valid and denied. It clears on an ALU grant or when `alu_valid=0`. When the counter is ≥ `STARVE_LIMIT`, the ALU wins. The counter saturates.
  - A lone requester is always granted immediately.
  - A granted request with rd=0 is accepted, but `rf_we` stays 0 for that slot. x0 is never written in RUN.
  - Both requesters may target the same rd. They are serialized in grant order, so the later write wins. There is no merging.
- Requester obligations:
  - A requester holds valid, rd and data stable until accepted.
  - Deasserting valid without acceptance is permitted. The block tracks no state for withdrawn requests.

## Timing
- All outputs are registered except `*_ready`.
- Reset values: `rf_we=0`, `rf_waddr=0`, `rf_wdata=0`, `init_done=0`, `*_ready=0`, starve counter 0.
- Clear sequence:
  - First clock edge after reset deassertion: `rf_we=1`, `rf_waddr=0`.
  - Addresses 0..31 follow on consecutive cycles (32 cycles).
  - On the next edge `init_done=1` and `rf_we=0`.
  - Grants are possible in that same cycle.
- Writeback latency: a request accepted in cycle N appears on `rf_we`/`rf_waddr`/`rf_wdata` in cycle N+1. The register file captures it at the end of N+1.
- Throughput: one write per cycle. There is no backpressure from the register file.
- If no grant occurs in cycle N, `rf_we=0` in N+1. `rf_waddr`/`rf_wdata` hold their previous values.
- Reset asserted mid-CLEAR or mid-RUN:
  - Immediately returns all outputs to their reset values.
  - Any write in flight is dropped.
  - The clear restarts from index 0 after deassertion.
- `init_done` stays 1 until the next reset.

## Configuration
- `RF_WB_RR_EN` defined:
  - Fixed priority and the starve counter are replaced by a 1-bit round-robin pointer.
  - On a conflict the requester not granted last wins. The pointer updates on every conflicting grant.
  - The pointer resets to favour mem.
  - `STARVE_LIMIT` is unused.
- `RF_WB_RR_EN` undefined: fixed mem priority with the starvation override, as in Operation.

## Structure
- Shared package `rf_pkg`:
  - `XLEN`, `ADDR_W`, `NUM_REGS=32`.
  - FSM state typedef {CLEAR, RUN}.
  - Writeback request struct {valid, rd, data}.
- One natural sub-module, `rf_wb_prio`: the combinational grant logic plus its arbitration state (starve counter or RR pointer). It outputs one-hot grant.
- The top level holds the FSM, the clear counter and the output registers.

## Test plan
- Clear sequence: reset for 3 cycles, then release → 32 consecutive cycles of `rf_we=1` with `rf_waddr` 0..31 and `rf_wdata=0`, then `init_done=1`; no ready during clear.
- Single requester: ALU valid with rd=5, data=0x1234 in RUN → `alu_ready=1` the same cycle; next cycle `rf_we=1`, `rf_waddr=5`, `rf_wdata=0x1234`.
- Conflict with starvation (default build, `STARVE_LIMIT=4`): both valid continuously with distinct rd → mem granted 4 cycles, ALU on the 5th, then mem again; rf outputs follow one cycle later.
- x0 and same-rd: mem rd=0 data=0xFF → accepted, `rf_we=0` next cycle. Both valid with rd=7 (mem 0xA, alu 0xB) → mem write then ALU write; the final value written to x7 is 0xB.
- Reset mid-run: reset asserted while `rf_we=1` → outputs zero immediately; after release the clear restarts at address 0 and `init_done=0` until it completes.
- `RF_WB_RR_EN` build: both valid continuously → grants alternate mem, alu, mem, alu starting with mem.
